// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: the control-flow
// opcodes that make fetch stall, and the fetch FSM state encoding.
package inst_fetch_pkg;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_PRESENT = 2'd1,
        ST_BRWAIT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory port between the fetch stage (master) and the
// instruction memory/cache (slave).
//
// Handshake: the master raises mem_req with a word-aligned mem_addr and holds
// both stable until the slave returns a single-cycle mem_valid pulse carrying
// mem_data for that address. There is no ready signal and at most one request
// is outstanding. A request is retired by the mem_valid pulse; the master may
// present a new address on the following cycle.
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_valid;
    logic [31:0]           mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_valid,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_valid,
        output mem_data
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction-fetch stage. Holds the fetch PC, issues one word read at a
// time, presents one instruction plus its PC to the decoder, and stalls after
// any control-flow instruction until redirected by the decoder or the ROB.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    inst_fetch_if.master          mem,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [31:0]           if_inst,
    output logic                  if_valid,
    input  logic                  need_inst,
    input  logic                  clear_inst,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  rob_clear,
    input  logic [ADDR_WIDTH-1:0] rob_clear_addr,
    output fetch_state_t          state_dbg
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc;
    // Set when the outstanding response belongs to a path we have left.
    logic                  drop;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  req_pending;

    // Predecode: does this opcode change control flow?
    function automatic logic is_ctrl(input logic [6:0] opcode);
        logic ctrl;
        ctrl = 1'b0;
        case (opcode)
            OPC_JAL, OPC_JALR, OPC_BRANCH: ctrl = 1'b1;
            default:                       ctrl = 1'b0;
        endcase
        return ctrl;
    endfunction

    // Redirect selection: the ROB flush outranks the decoder redirect.
    always_comb begin
        redirect        = rob_clear | clear_inst;
        redirect_target = rob_clear ? rob_clear_addr : if_addr;
        pc_next         = pc + ADDR_WIDTH'(4);
        req_pending     = (state == ST_FETCH) && mem.mem_req && !mem.mem_valid;
    end

    // Fetch FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= RESET_PC;
            state        <= ST_FETCH;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= RESET_PC;
            if_valid     <= 1'b0;
            if_inst      <= '0;
            if_pc        <= '0;
            drop         <= 1'b0;
        end else if (rdy) begin
            if (redirect) begin
                pc       <= redirect_target;
                if_valid <= 1'b0;
                if (req_pending) begin
                    // Address must stay put until the old response drains.
                    drop <= 1'b1;
                end else begin
                    mem.mem_addr <= redirect_target;
                    mem.mem_req  <= 1'b1;
                    state        <= ST_FETCH;
                    drop         <= 1'b0;
                end
            end else begin
                case (state)
                    ST_FETCH: begin
                        if (mem.mem_valid) begin
                            if (drop) begin
                                // Stale data: reissue at the redirected pc.
                                drop         <= 1'b0;
                                mem.mem_addr <= pc;
                            end else begin
                                if_inst     <= mem.mem_data;
                                if_pc       <= pc;
                                if_valid    <= 1'b1;
                                mem.mem_req <= 1'b0;
                                state       <= ST_PRESENT;
                            end
                        end
                    end
                    ST_PRESENT: begin
                        if (if_valid && need_inst) begin
                            if_valid <= 1'b0;
                            if (is_ctrl(if_inst[6:0])) begin
                                // Never fetch past control flow; wait for a redirect.
                                state <= ST_BRWAIT;
                            end else begin
                                pc           <= pc_next;
                                mem.mem_addr <= pc_next;
                                mem.mem_req  <= 1'b1;
                                state        <= ST_FETCH;
                            end
                        end
                    end
                    ST_BRWAIT: begin
                        if_valid    <= 1'b0;
                        mem.mem_req <= 1'b0;
                    end
                    default: begin
                        state       <= ST_FETCH;
                        mem.mem_req <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by a randomized run
// checked against a PC-stream reference model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic         clk;
    logic         rst;
    logic         rdy;
    logic         need_inst;
    logic         clear_inst;
    logic         rob_clear;
    logic [31:0]  if_addr;
    logic [31:0]  rob_clear_addr;
    logic [31:0]  if_pc;
    logic [31:0]  if_inst;
    logic         if_valid;
    fetch_state_t state_dbg;

    int n_asserts = 0;
    int n_fail    = 0;

    // Memory model state
    int mem_cnt = 0;
    int mem_lat = 2;
    int lat_lo  = 2;
    int lat_hi  = 2;

    // Scoreboard: next PC the decoder should see (empty while stalled on control flow)
    logic [31:0] exp_q[$];

    // Frozen-output snapshot
    logic [31:0]  s_pc, s_inst, s_addr;
    logic         s_valid, s_req;
    fetch_state_t s_state;

    inst_fetch_if #(.ADDR_WIDTH(32)) bus ();

    inst_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .mem            (bus),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .need_inst      (need_inst),
        .clear_inst     (clear_inst),
        .if_addr        (if_addr),
        .rob_clear      (rob_clear),
        .rob_clear_addr (rob_clear_addr),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- reference helpers ----------------
    // Program image: straight-line addi-style words below 0x1000 (jal at 0x10),
    // hashed mix of control / non-control words above.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  opc;
        if (a == 32'h10) return 32'h0080006f;
        if (a < 32'h1000) return {a[24:0], 7'h13};
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        case (h[2:0])
            3'd0:    opc = 7'b1101111;
            3'd1:    opc = 7'b1100011;
            3'd2:    opc = 7'b1100111;
            default: opc = 7'b0010011;
        endcase
        return {h[31:7], opc};
    endfunction

    function automatic logic ctrl_word(input logic [31:0] w);
        return (w[6:0] inside {7'b1101111, 7'b1100111, 7'b1100011});
    endfunction

    function automatic logic [31:0] rand_target();
        return 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock; afterwards the memory model decides its response for the next edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (!rst) begin
            bus.mem_valid = 1'b0;
            mem_cnt       = 0;
        end else if (bus.mem_valid) begin
            bus.mem_valid = 1'b0;
            mem_cnt       = 0;
            mem_lat       = int'($urandom_range(lat_hi, lat_lo));
        end else if (rdy && bus.mem_req) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                bus.mem_valid = 1'b1;
                bus.mem_data  = word_at(bus.mem_addr);
            end
        end
    endtask

    // Memory never responds while rdy is low.
    task automatic set_rdy(input logic v);
        rdy = v;
        if (!v) begin
            bus.mem_valid = 1'b0;
            mem_cnt       = 0;
        end
    endtask

    task automatic wait_present(input logic [31:0] exp_pc, input string tag);
        int n;
        n = 0;
        while (!if_valid && n < 40) begin
            cycle();
            n++;
        end
        check({tag, "_valid"}, 32'(if_valid), 32'h1);
        check({tag, "_pc"}, if_pc, exp_pc);
        check({tag, "_inst"}, if_inst, word_at(exp_pc));
    endtask

    task automatic take(input string tag);
        need_inst = 1'b1;
        cycle();
        need_inst = 1'b0;
        check({tag, "_taken"}, 32'(if_valid), 32'h0);
    endtask

    task automatic snapshot();
        s_pc = if_pc; s_inst = if_inst; s_valid = if_valid;
        s_req = bus.mem_req; s_addr = bus.mem_addr; s_state = state_dbg;
    endtask

    task automatic check_frozen(input string tag);
        check({tag, "_pc"},    if_pc,              s_pc);
        check({tag, "_inst"},  if_inst,            s_inst);
        check({tag, "_valid"}, 32'(if_valid),      32'(s_valid));
        check({tag, "_req"},   32'(bus.mem_req),   32'(s_req));
        check({tag, "_addr"},  bus.mem_addr,       s_addr);
        check({tag, "_state"}, 32'(state_dbg),     32'(s_state));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic        rdy_v;
        logic        waiting;
        int          gap;
        int          wcnt;
        int          handoffs;
        int          n;
        logic [31:0] exp_pc;

        rst = 1'b0; rdy = 1'b1; need_inst = 1'b0; clear_inst = 1'b0; rob_clear = 1'b0;
        if_addr = '0; rob_clear_addr = '0;
        bus.mem_valid = 1'b0; bus.mem_data = '0;

        // Reset state
        repeat (3) cycle();
        check("rst_req",   32'(bus.mem_req), 32'h1);
        check("rst_addr",  bus.mem_addr,     32'h0);
        check("rst_valid", 32'(if_valid),    32'h0);
        check("rst_inst",  if_inst,          32'h0);
        check("rst_pc",    if_pc,            32'h0);
        check("rst_state", 32'(state_dbg),   32'(ST_FETCH));
        rst = 1'b1;

        // First fetch at 0, decoder not ready
        wait_present(32'h0, "first");
        check("first_req_off", 32'(bus.mem_req), 32'h0);

        // Decoder holds off for 5 cycles
        repeat (5) cycle();
        check("hold_pc",    if_pc,            32'h0);
        check("hold_inst",  if_inst,          32'h13);
        check("hold_valid", 32'(if_valid),    32'h1);
        check("hold_req",   32'(bus.mem_req), 32'h0);

        // Handoff -> next fetch one cycle later
        take("h0");
        check("h0_addr", bus.mem_addr,     32'h4);
        check("h0_req",  32'(bus.mem_req), 32'h1);

        for (int i = 1; i < 4; i++) begin
            wait_present(32'(i * 4), "seq");
            take("seq");
        end

        // jal at 0x10: stall until decoder redirect
        wait_present(32'h10, "jal");
        take("jal");
        check("jal_state", 32'(state_dbg),   32'(ST_BRWAIT));
        check("jal_req",   32'(bus.mem_req), 32'h0);
        repeat (3) cycle();
        check("brwait_req",   32'(bus.mem_req), 32'h0);
        check("brwait_valid", 32'(if_valid),    32'h0);
        clear_inst = 1'b1; if_addr = 32'h18;
        cycle();
        clear_inst = 1'b0;
        check("redir_addr", bus.mem_addr,     32'h18);
        check("redir_req",  32'(bus.mem_req), 32'h1);

        present_0x18: begin
            wait_present(32'h18, "tgt");
            take("tgt");
        end

        // rob_clear while request to 0x20 is outstanding
        wait_present(32'h1c, "pre_rob");
        lat_lo = 4; lat_hi = 4; mem_lat = 4;
        take("pre_rob");
        check("out_addr", bus.mem_addr, 32'h20);
        rob_clear = 1'b1; rob_clear_addr = 32'h100;
        cycle();
        rob_clear = 1'b0;
        check("drop_addr",  bus.mem_addr,     32'h20);
        check("drop_req",   32'(bus.mem_req), 32'h1);
        check("drop_valid", 32'(if_valid),    32'h0);
        n = 0;
        begin : drain
            logic had_valid;
            had_valid = 1'b0;
            while (!had_valid && n < 20) begin
                had_valid = bus.mem_valid;
                cycle();
                n++;
                if (!had_valid) check("drain_addr", bus.mem_addr, 32'h20);
                check("drain_valid", 32'(if_valid), 32'h0);
            end
            check("drain_seen", 32'(had_valid), 32'h1);
        end
        check("reissue_addr", bus.mem_addr,     32'h100);
        check("reissue_req",  32'(bus.mem_req), 32'h1);
        lat_lo = 2; lat_hi = 2;
        wait_present(32'h100, "rob_tgt");
        take("rob_tgt");

        // rob_clear and clear_inst together: ROB wins
        rob_clear = 1'b1; rob_clear_addr = 32'h200;
        clear_inst = 1'b1; if_addr = 32'h300;
        cycle();
        rob_clear = 1'b0; clear_inst = 1'b0;
        wait_present(32'h200, "prio");

        // rdy low mid-PRESENT, with need_inst asserted
        set_rdy(1'b0);
        need_inst = 1'b1;
        snapshot();
        repeat (3) begin
            cycle();
            check_frozen("frz_present");
        end
        set_rdy(1'b1);
        cycle();
        need_inst = 1'b0;
        check("thaw_valid", 32'(if_valid), 32'h0);
        check("thaw_addr",  bus.mem_addr,  32'h204);

        // rdy low mid-FETCH
        set_rdy(1'b0);
        snapshot();
        repeat (3) begin
            cycle();
            check_frozen("frz_fetch");
        end
        set_rdy(1'b1);
        wait_present(32'h204, "post_frz");
        take("post_frz");

        // Asynchronous reset mid-FETCH
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(if_valid),    32'h0);
        check("arst_addr",  bus.mem_addr,     32'h0);
        check("arst_req",   32'(bus.mem_req), 32'h1);
        check("arst_pc",    if_pc,            32'h0);
        check("arst_state", 32'(state_dbg),   32'(ST_FETCH));
        cycle();
        cycle();
        rst = 1'b1;

        // ---------------- randomized run ----------------
        lat_lo = 1; lat_hi = 3;
        exp_q.delete();
        exp_q.push_back(32'h0);
        waiting  = 1'b0;
        gap      = 0;
        wcnt     = 0;
        handoffs = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy_v = ($urandom_range(0, 9) != 0);
            set_rdy(rdy_v);
            need_inst      = ($urandom_range(0, 9) < 7);
            rob_clear      = ($urandom_range(0, 49) == 0);
            rob_clear_addr = rand_target();
            if_addr        = rand_target();
            if (waiting) clear_inst = (wcnt >= gap);
            else         clear_inst = ($urandom_range(0, 49) == 0);

            if (rdy_v) begin
                if (rob_clear || clear_inst) begin
                    exp_q.delete();
                    exp_q.push_back(rob_clear ? rob_clear_addr : if_addr);
                    waiting = 1'b0;
                end else if (if_valid && need_inst) begin
                    if (exp_q.size() == 0) begin
                        check("present_while_wait", 32'(if_valid), 32'h0);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        check("rnd_pc",   if_pc,   exp_pc);
                        check("rnd_inst", if_inst, word_at(exp_pc));
                        handoffs++;
                        if (ctrl_word(word_at(exp_pc))) begin
                            waiting = 1'b1;
                            gap     = int'($urandom_range(0, 4));
                            wcnt    = 0;
                        end else begin
                            exp_q.push_back(exp_pc + 32'h4);
                        end
                    end
                end else if (waiting) begin
                    wcnt++;
                end
            end

            cycle();
            rob_clear  = 1'b0;
            clear_inst = 1'b0;

            if (waiting) begin
                check("rnd_wait_valid", 32'(if_valid),    32'h0);
                check("rnd_wait_req",   32'(bus.mem_req), 32'h0);
            end
        end
        check("rnd_progress", 32'(handoffs >= 200), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the decoder.
- Holds the architectural fetch PC and issues one word-read request at a time to the instruction memory/cache port.
- Presents one instruction plus its PC to the decoder.
- Stalls after any control-flow instruction until redirected by the decoder (clear_inst/if_addr) or by the ROB on mispredict.

Parameters:
- RESET_PC, 32'h0, PC loaded on reset.
- ADDR_WIDTH, 32, width of PC/addresses.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- rdy  in  1  global enable; low = freeze all state
- mem_req  out  1  fetch request valid
- mem_addr  out  ADDR_WIDTH  fetch address, word-aligned
- mem_valid  in  1  one-cycle pulse, mem_data valid for current request
- mem_data  in  32  fetched instruction word
- if_pc  out  ADDR_WIDTH  PC of presented instruction (decoder PC)
- if_inst  out  32  presented instruction (decoder inst_in)
- if_valid  out  1  presented instruction valid (decoder instcache_ready_out)
- need_inst  in  1  decoder can accept/has consumed the presented instruction
- clear_inst  in  1  decoder redirect pulse
- if_addr  in  ADDR_WIDTH  decoder redirect target
- rob_clear  in  1  ROB mispredict flush pulse
- rob_clear_addr  in  ADDR_WIDTH  ROB correct-path target

Behaviour:
- Reset (rst low, async): pc=RESET_PC; state=FETCH; mem_req=1; mem_addr=RESET_PC; if_valid=0; if_inst=0; if_pc=0; drop=0.
- rdy low: no state or output changes; mem_valid is not asserted while rdy is low.
- All outputs are registered.
- States: FETCH, PRESENT, BRWAIT.
- FETCH:
  - mem_req=1; mem_addr=pc, held stable until mem_valid.
  - On mem_valid with drop=0: if_inst<=mem_data; if_pc<=pc; if_valid<=1; mem_req<=0; next state PRESENT.
  - On mem_valid with drop=1: discard data; drop<=0; mem_addr<=pc (the redirected pc); mem_req stays 1; stay in FETCH.
- PRESENT:
  - Handoff occurs at a clock edge with if_valid && need_inst.
  - Control opcode (1101111 jal, 1100111 jalr, 1100011 branch):
    - if_valid<=0; state BRWAIT.
    - No fetch is issued, so no wrong-path instruction is ever presented.
    - Decoder predicts branches taken and redirects all three via clear_inst.
  - Other opcode:
    - if_valid<=0; pc<=pc+4 (mod 2^32); mem_addr<=pc+4; mem_req<=1; state FETCH.
    - Next-fetch latency is 1 cycle after handoff.
- BRWAIT:
  - if_valid=0; mem_req=0.
  - On clear_inst: pc<=if_addr; mem_addr<=if_addr; mem_req<=1; state FETCH.
- Redirects (any state):
  - rob_clear has priority over clear_inst and over handoff.
  - Effect: pc<=target; if_valid<=0.
  - If state FETCH and a request is outstanding (mem_req=1, no mem_valid this cycle): drop<=1, mem_addr is unchanged until the pending response returns.
  - If mem_valid coincides with a redirect: discard data; reissue at target next cycle with drop=0.
  - Otherwise: mem_addr<=target; mem_req<=1; state FETCH.
- clear_inst in PRESENT or FETCH is honoured as a redirect by the same rules.
- Targets are used as given; the decoder clears bit 0 for jalr. No misalignment checks.
- Decoder detects new instructions by PC change. Fetch never re-presents the same if_pc twice consecutively except after a redirect to that same address, which is a software hazard and out of scope.

Decomposition:
- Shared package/const include: opcode constants (OPC_JAL, OPC_JALR, OPC_BRANCH) and state encodings (2 bits).
- Single module with an is_ctrl combinational predecode function.
- No sub-module.

Test Plan:
- Reset, memory returns 0x00000013 at addr 0 after 2 cycles -> mem_req=1/mem_addr=0; if_valid=1, if_pc=0 the cycle after mem_valid; after handoff mem_addr=4 next cycle.
- need_inst held 0 for 5 cycles while if_valid=1 -> if_inst/if_pc stable, mem_req=0, no pc advance.
- Present jal 0x0080006f at pc=0x10, handoff -> if_valid=0, mem_req=0 until clear_inst with if_addr=0x18; then mem_addr=0x18 next cycle.
- rob_clear with target 0x100 while request to 0x20 is outstanding -> mem_addr stays 0x20 until mem_valid; that data is never presented; next request at 0x100; first if_pc=0x100.
- rob_clear and clear_inst in same cycle (0x200 vs 0x300) -> fetch resumes at 0x200.
- rdy low for 3 cycles mid-FETCH and mid-PRESENT -> all outputs unchanged; rst low mid-FETCH -> immediate if_valid=0, mem_addr=RESET_PC.
